// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings, per-stage control struct and opcode decode for pipeline_control.
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int unsigned CTRL_ALU_OP_W = 2;

    localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_R      = 2'b10;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_IMM    = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                     branch;
        logic [CTRL_ALU_OP_W-1:0] alu_op;
        logic                     alu_src;
        logic                     mem_read;
        logic                     mem_write;
        logic                     mem_to_reg;
        logic                     reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = CTRL_BUBBLE;
        case (opcode)
            OPC_R: begin
                c.alu_op    = ALU_OP_R;
                c.reg_write = 1'b1;
            end
            OPC_IMM: begin
                c.alu_op    = ALU_OP_IMM;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                c.alu_op     = ALU_OP_ADD;
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            OPC_STORE: begin
                c.alu_op    = ALU_OP_ADD;
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                c.alu_op = ALU_OP_BRANCH;
                c.branch = 1'b1;
            end
            default: c = CTRL_BUBBLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_control_hazard.sv
// hazard_unit: load-use detection against the EX load and EX-stage operand forwarding selects.
module hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  load_use,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    // MEM result is younger than WB, so it wins when both write the same register.
    function automatic logic [1:0] fwd_select(input logic [REG_ADDR_W-1:0] src);
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
            return FWD_MEM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    always_comb begin
        load_use = 1'b0;
        if (ex_mem_read && (ex_rd != '0)) begin
            load_use = (id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2));
        end
        fwd_a = fwd_select(ex_rs1);
        fwd_b = fwd_select(ex_rs2);
    end

endmodule

// File: rtl/pipeline_control.sv
// Control/hazard block of the 5-stage RV32I core: decode, ID/EX-EX/MEM-MEM/WB control copies,
// load-use stall, forwarding and EX branch resolution. Define BRANCH_EXT_EN for full branch decode.
module pipeline_control
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_OP_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [2:0]            id_funct3,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_zero,
    input  logic                  ex_lt,
    input  logic                  ex_ltu,
    output logic                  stall,
    output logic                  flush,
    output logic                  pc_src,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic                  ex_alu_src,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_mem_to_reg,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    ctrl_t                 id_ctrl;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  load_use;
    logic                  taken;
    logic                  insert_bubble;

    ctrl_t                 id_ex_ctrl;
    logic [REG_ADDR_W-1:0] id_ex_rs1;
    logic [REG_ADDR_W-1:0] id_ex_rs2;
    logic [REG_ADDR_W-1:0] id_ex_rd;
`ifdef BRANCH_EXT_EN
    logic [2:0]            id_ex_funct3;
`else
    logic                  unused_branch_inputs;
    assign unused_branch_inputs = ^{id_funct3, ex_lt, ex_ltu};
`endif

    logic                  ex_mem_mem_read;
    logic                  ex_mem_mem_write;
    logic                  ex_mem_mem_to_reg;
    logic                  ex_mem_reg_write;
    logic [REG_ADDR_W-1:0] ex_mem_rd;

    logic                  mem_wb_mem_to_reg;
    logic                  mem_wb_reg_write;
    logic [REG_ADDR_W-1:0] mem_wb_rd;

    always_comb begin
        id_ctrl    = CTRL_BUBBLE;
        id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0;
        if (id_valid) begin
            id_ctrl    = decode_ctrl(id_opcode);
            id_use_rs1 = (id_opcode == OPC_R) || (id_opcode == OPC_IMM) ||
                         (id_opcode == OPC_LOAD) || (id_opcode == OPC_STORE) ||
                         (id_opcode == OPC_BRANCH);
            id_use_rs2 = (id_opcode == OPC_R) || (id_opcode == OPC_STORE) ||
                         (id_opcode == OPC_BRANCH);
        end
    end

    always_comb begin
        taken = 1'b0;
`ifdef BRANCH_EXT_EN
        case (id_ex_funct3)
            3'b000:  taken = ex_zero;
            3'b001:  taken = !ex_zero;
            3'b100:  taken = ex_lt;
            3'b101:  taken = !ex_lt;
            3'b110:  taken = ex_ltu;
            3'b111:  taken = !ex_ltu;
            default: taken = 1'b0;
        endcase
`else
        taken = ex_zero;
`endif
    end

    hazard_unit #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_mem_read   (id_ex_ctrl.mem_read),
        .ex_rd         (id_ex_rd),
        .ex_rs1        (id_ex_rs1),
        .ex_rs2        (id_ex_rs2),
        .mem_reg_write (ex_mem_reg_write),
        .mem_rd        (ex_mem_rd),
        .wb_reg_write  (mem_wb_reg_write),
        .wb_rd         (mem_wb_rd),
        .load_use      (load_use),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    // A taken branch squashes the ID instruction anyway, so it overrides the load-use stall.
    assign pc_src        = id_ex_ctrl.branch & taken;
    assign flush         = pc_src;
    assign stall         = load_use & ~pc_src;
    assign insert_bubble = stall | pc_src | (id_ctrl == CTRL_BUBBLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_ctrl        <= CTRL_BUBBLE;
            id_ex_rs1         <= '0;
            id_ex_rs2         <= '0;
            id_ex_rd          <= '0;
`ifdef BRANCH_EXT_EN
            id_ex_funct3      <= '0;
`endif
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_mem_to_reg <= 1'b0;
            ex_mem_reg_write  <= 1'b0;
            ex_mem_rd         <= '0;
            mem_wb_mem_to_reg <= 1'b0;
            mem_wb_reg_write  <= 1'b0;
            mem_wb_rd         <= '0;
        end else begin
            if (insert_bubble) begin
                id_ex_ctrl   <= CTRL_BUBBLE;
                id_ex_rs1    <= '0;
                id_ex_rs2    <= '0;
                id_ex_rd     <= '0;
`ifdef BRANCH_EXT_EN
                id_ex_funct3 <= '0;
`endif
            end else begin
                id_ex_ctrl   <= id_ctrl;
                id_ex_rs1    <= id_rs1;
                id_ex_rs2    <= id_rs2;
                id_ex_rd     <= id_rd;
`ifdef BRANCH_EXT_EN
                id_ex_funct3 <= id_funct3;
`endif
            end
            ex_mem_mem_read   <= id_ex_ctrl.mem_read;
            ex_mem_mem_write  <= id_ex_ctrl.mem_write;
            ex_mem_mem_to_reg <= id_ex_ctrl.mem_to_reg;
            ex_mem_reg_write  <= id_ex_ctrl.reg_write;
            ex_mem_rd         <= id_ex_rd;
            mem_wb_mem_to_reg <= ex_mem_mem_to_reg;
            mem_wb_reg_write  <= ex_mem_reg_write;
            mem_wb_rd         <= ex_mem_rd;
        end
    end

    assign ex_alu_op     = ALU_OP_W'(id_ex_ctrl.alu_op);
    assign ex_alu_src    = id_ex_ctrl.alu_src;
    assign mem_read      = ex_mem_mem_read;
    assign mem_write     = ex_mem_mem_write;
    assign wb_mem_to_reg = mem_wb_mem_to_reg;
    assign wb_reg_write  = mem_wb_reg_write;
    assign wb_rd         = mem_wb_rd;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_pipeline_control;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_UNK = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [2:0] id_funct3;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_zero, ex_lt, ex_ltu;
    logic       stall, flush, pc_src;
    logic [1:0] ex_alu_op;
    logic       ex_alu_src;
    logic [1:0] fwd_a, fwd_b;
    logic       mem_read, mem_write;
    logic       wb_mem_to_reg, wb_reg_write;
    logic [4:0] wb_rd;

    pipeline_control #(
        .REG_ADDR_W(5),
        .ALU_OP_W  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_funct3     (id_funct3),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .ex_zero       (ex_zero),
        .ex_lt         (ex_lt),
        .ex_ltu        (ex_ltu),
        .stall         (stall),
        .flush         (flush),
        .pc_src        (pc_src),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd)
    );

    always #5 clk = ~clk;

    typedef enum int {
        S_STALL, S_FLUSH, S_PCSRC, S_ALUOP, S_ALUSRC, S_FWDA, S_FWDB,
        S_MEMRD, S_MEMWR, S_WBM2R, S_WBRW, S_WBRD
    } sig_e;

    typedef struct {
        int    cyc;
        sig_e  sig;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sample(input sig_e s);
        case (s)
            S_STALL:  return int'(stall);
            S_FLUSH:  return int'(flush);
            S_PCSRC:  return int'(pc_src);
            S_ALUOP:  return int'(ex_alu_op);
            S_ALUSRC: return int'(ex_alu_src);
            S_FWDA:   return int'(fwd_a);
            S_FWDB:   return int'(fwd_b);
            S_MEMRD:  return int'(mem_read);
            S_MEMWR:  return int'(mem_write);
            S_WBM2R:  return int'(wb_mem_to_reg);
            S_WBRW:   return int'(wb_reg_write);
            S_WBRD:   return int'(wb_rd);
            default:  return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (sample(sb[i].sig) != sb[i].val) begin
                    failures++;
                    $display("FAIL %s (cycle %0d): got %0d, expected %0d",
                             sb[i].name, cyc, sample(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic exp_push(input int dly, input sig_e s, input int v, input string nm);
        sb.push_back('{cyc: cyc + dly, sig: s, val: v, name: nm});
    endtask

    task automatic exp_all_zero(input string tag);
        for (int s = int'(S_STALL); s <= int'(S_WBRD); s++) begin
            exp_push(0, sig_e'(s), 0, $sformatf("%s_sig%0d", tag, s));
        end
    endtask

    task automatic issue(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        @(posedge clk);
        #1;
        id_valid  = v;
        id_opcode = op;
        id_funct3 = f3;
        id_rs1    = a;
        id_rs2    = b;
        id_rd     = d;
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_opcode = '0; id_funct3 = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        ex_zero = 1'b0; ex_lt = 1'b0; ex_ltu = 1'b0;

        // reset state
        idle(1);
        exp_all_zero("reset");
        idle(1);
        rst = 1'b0;
        idle(2);

        // load-use: LOAD x5 ; ADD x6,x5,x7
        issue(1, OP_LD, 3'b010, 5'd1, 5'd0, 5'd5);
        exp_push(0, S_STALL, 0, "lu_no_stall_yet");
        issue(1, OP_R, 3'b000, 5'd5, 5'd7, 5'd6);
        exp_push(0, S_STALL, 1, "lu_stall");
        exp_push(0, S_FLUSH, 0, "lu_flush");
        exp_push(0, S_ALUSRC, 1, "lu_ex_load_src");
        issue(1, OP_R, 3'b000, 5'd5, 5'd7, 5'd6);
        exp_push(0, S_STALL, 0, "lu_stall_one_cycle");
        exp_push(0, S_ALUOP, 0, "lu_bubble_aluop");
        exp_push(0, S_ALUSRC, 0, "lu_bubble_alusrc");
        exp_push(0, S_MEMRD, 1, "lu_mem_read");
        idle(1);
        exp_push(0, S_ALUOP, 2, "lu_add_in_ex");
        exp_push(0, S_FWDA, 1, "lu_fwd_a_wb");
        exp_push(0, S_FWDB, 0, "lu_fwd_b_none");
        exp_push(0, S_WBRD, 5, "lu_wb_rd");
        exp_push(0, S_WBM2R, 1, "lu_wb_m2r");
        idle(3);

        // back-to-back ALU: ADD x3,x1,x2 ; ADDI x3,x3 ; SUB x4,x3,x3
        issue(1, OP_R, 3'b000, 5'd1, 5'd2, 5'd3);
        issue(1, OP_I, 3'b000, 5'd3, 5'd0, 5'd3);
        exp_push(0, S_STALL, 0, "alu_no_stall_1");
        issue(1, OP_R, 3'b000, 5'd3, 5'd3, 5'd4);
        exp_push(0, S_STALL, 0, "alu_no_stall_2");
        exp_push(0, S_ALUOP, 3, "addi_aluop");
        exp_push(0, S_ALUSRC, 1, "addi_alusrc");
        exp_push(0, S_FWDA, 2, "addi_fwd_a_mem");
        exp_push(0, S_FWDB, 0, "addi_fwd_b_none");
        idle(1);
        exp_push(0, S_FWDA, 2, "sub_fwd_a_mem_prio");
        exp_push(0, S_FWDB, 2, "sub_fwd_b_mem_prio");
        idle(1);
        exp_push(0, S_FWDA, 0, "bubble_fwd_a");
        exp_push(0, S_WBRD, 3, "addi_wb_rd");
        idle(3);

        // taken BEQ, younger ADD squashed
        issue(1, OP_B, 3'b000, 5'd1, 5'd2, 5'd0);
        issue(1, OP_R, 3'b000, 5'd5, 5'd7, 5'd6);
        ex_zero = 1'b1;
        exp_push(0, S_PCSRC, 1, "beq_pc_src");
        exp_push(0, S_FLUSH, 1, "beq_flush");
        exp_push(0, S_STALL, 0, "beq_stall");
        issue(1, OP_I, 3'b000, 5'd1, 5'd0, 5'd8);
        ex_zero = 1'b0;
        exp_push(0, S_ALUOP, 0, "beq_bubble_aluop");
        exp_push(0, S_ALUSRC, 0, "beq_bubble_alusrc");
        exp_push(0, S_PCSRC, 0, "beq_pc_src_clear");
        idle(1);
        exp_push(0, S_ALUOP, 3, "beq_target_in_ex");
        idle(3);

        // not-taken BEQ lets the next instruction through
        issue(1, OP_B, 3'b000, 5'd1, 5'd2, 5'd0);
        issue(1, OP_R, 3'b000, 5'd5, 5'd7, 5'd6);
        exp_push(0, S_PCSRC, 0, "beq_nt_pc_src");
        exp_push(0, S_FLUSH, 0, "beq_nt_flush");
        idle(1);
        exp_push(0, S_ALUOP, 2, "beq_nt_add_in_ex");
        idle(3);

`ifdef BRANCH_EXT_EN
        issue(1, OP_B, 3'b100, 5'd1, 5'd2, 5'd0);
        idle(1);
        ex_lt = 1'b1;
        exp_push(0, S_PCSRC, 1, "blt_taken");
        idle(1);
        ex_lt = 1'b0;
        idle(2);
        issue(1, OP_B, 3'b111, 5'd1, 5'd2, 5'd0);
        idle(1);
        ex_ltu = 1'b1;
        exp_push(0, S_PCSRC, 0, "bgeu_not_taken");
        exp_push(0, S_FLUSH, 0, "bgeu_no_flush");
        idle(1);
        ex_ltu = 1'b0;
        idle(2);
`else
        issue(1, OP_B, 3'b001, 5'd1, 5'd2, 5'd0);
        idle(1);
        ex_zero = 1'b1;
        exp_push(0, S_PCSRC, 1, "bne_beq_only_taken");
        idle(1);
        ex_zero = 1'b0;
        idle(2);
`endif

        // x0 is never a hazard or forwarding source
        issue(1, OP_LD, 3'b010, 5'd1, 5'd0, 5'd0);
        issue(1, OP_R, 3'b000, 5'd0, 5'd0, 5'd6);
        exp_push(0, S_STALL, 0, "x0_no_stall");
        idle(1);
        exp_push(0, S_FWDA, 0, "x0_fwd_a");
        exp_push(0, S_FWDB, 0, "x0_fwd_b");
        idle(3);

        // unknown opcode writes nothing
        issue(1, OP_R, 3'b000, 5'd1, 5'd2, 5'd9);
        issue(1, OP_UNK, 3'b000, 5'd1, 5'd2, 5'd9);
        exp_push(2, S_WBRW, 1, "add_wb_reg_write");
        exp_push(2, S_WBRD, 9, "add_wb_rd");
        exp_push(3, S_WBRW, 0, "unk_wb_reg_write");
        exp_push(3, S_WBRD, 0, "unk_wb_rd");
        idle(5);

        // reset during a load-use stall
        issue(1, OP_LD, 3'b010, 5'd1, 5'd0, 5'd5);
        issue(1, OP_R, 3'b000, 5'd5, 5'd7, 5'd6);
        rst = 1'b1;
        exp_push(0, S_STALL, 1, "rst_pre_stall");
        issue(1, OP_R, 3'b000, 5'd5, 5'd7, 5'd6);
        rst = 1'b0;
        exp_all_zero("midrst");
        exp_push(1, S_ALUOP, 2, "rst_refill_aluop");
        exp_push(3, S_WBRW, 1, "rst_refill_wb_rw");
        exp_push(3, S_WBRD, 6, "rst_refill_wb_rd");
        idle(6);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
